load_store_unit: RTL and testbench

- Execution stage directly downstream of instruction dispatch. Consumes the two load/store lanes (A, B) and serialises them into one single-port data-memory request/acknowledge interface.
- Returns load results as a single writeback to the register file.
- Internal request FIFO accepts up to two ops per cycle and back-pressures dispatch with stall_o.

---
 rtl/load_store_unit_pkg.sv | 54 +++++
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit_fifo.sv | 85 ++++++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, request-entry layout,
// FSM state encoding and small helpers used by the FIFO and the control logic.
package ls_defs;

  localparam logic [6:0] OP_LOAD  = 7'h20;
  localparam logic [6:0] OP_STORE = 7'h21;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 5;

  // Bit layout of a queued request: {we, wb_en, wb_addr, addr, data}
  localparam int DATA_LSB   = 0;
  localparam int ADDR_LSB   = DATA_LSB + DATA_W;
  localparam int WBADDR_LSB = ADDR_LSB + ADDR_W;
  localparam int WBEN_BIT   = WBADDR_LSB + REG_W;
  localparam int WE_BIT     = WBEN_BIT + 1;
  localparam int ENTRY_W    = WE_BIT + 1;

  typedef struct packed {
    logic              we;
    logic              wb_en;
    logic [REG_W-1:0]  wb_addr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ls_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } ls_state_e;

  function automatic logic is_ls_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Stores never write back; loads write back only when dispatch asks for it.
  function automatic ls_entry_t make_entry(
    input logic [6:0]        op,
    input logic              is_wb,
    input logic [REG_W-1:0]  wb_addr,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    ls_entry_t e;
    e.we      = (op == OP_STORE);
    e.wb_en   = is_wb & (op == OP_LOAD);
    e.wb_addr = wb_addr;
    e.addr    = addr;
    e.data    = data;
    return e;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Single-port data-memory request/acknowledge bus between the load/store unit
// (master) and the data memory (slave).
interface load_store_unit_if;
  import ls_defs::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_fifo.sv
// Request FIFO for the load/store unit: two in-order write slots per cycle,
// one read, combinational head, synchronous clear.
module ls_request_fifo
  import ls_defs::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear,
  input  logic             wr0_en,
  input  ls_entry_t        wr0_entry,
  input  logic             wr1_en,
  input  ls_entry_t        wr1_entry,
  input  logic             pop,
  output ls_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [ENTRY_W-1:0] slot_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [PTR_W-1:0]   wr1_ptr;
  logic [ENTRY_W-1:0] rd_word;

  // Slot 1 lands just after slot 0; pointers wrap naturally at DEPTH.
  assign wr1_ptr = wr0_en ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clock_i) begin
        if (wr0_en && (wr_ptr_reg == PTR_W'(gi))) begin
          slot_reg[gi] <= wr0_entry;
        end else if (wr1_en && (wr1_ptr == PTR_W'(gi))) begin
          slot_reg[gi] <= wr1_entry;
        end
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(wr0_en) + PTR_W'(wr1_en);
      rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
      count_next  = count_reg + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    rd_word      = slot_reg[rd_ptr_reg];
    head.we      = rd_word[WE_BIT];
    head.wb_en   = rd_word[WBEN_BIT];
    head.wb_addr = rd_word[WBADDR_LSB +: REG_W];
    head.addr    = rd_word[ADDR_LSB +: ADDR_W];
    head.data    = rd_word[DATA_LSB +: DATA_W];
  end

  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/load_store_unit.sv
// Load/store execution stage: queues ops from two dispatch lanes, serialises
// them onto one data-memory port and returns load data as a single writeback.
module load_store_unit
  import ls_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              loadStoreA_i,
  input  logic              loadStoreB_i,
  input  logic              isWbLSA_i,
  input  logic              isWbLSB_i,
  input  logic [REG_W-1:0]  lsWbAddressA_i,
  input  logic [REG_W-1:0]  lsWbAddressB_i,
  input  logic [6:0]        lsOpCodeA_i,
  input  logic [6:0]        lsOpCodeB_i,
  input  logic [ADDR_W-1:0] lsPoperandA_i,
  input  logic [ADDR_W-1:0] lsPoperandB_i,
  input  logic [DATA_W-1:0] lsSoperandA_i,
  input  logic [DATA_W-1:0] lsSoperandB_i,
  output logic              stall_o,
  load_store_unit_if.master mem_bus,
  output logic              wbEnable_o,
  output logic [REG_W-1:0]  wbAddress_o,
  output logic [DATA_W-1:0] wbData_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ls_state_e         state_reg, state_next;
  ls_entry_t         cur_reg, cur_next;
  logic              squash_reg, squash_next;
  logic              wb_en_reg, wb_en_next;
  logic [REG_W-1:0]  wb_addr_reg, wb_addr_next;
  logic [DATA_W-1:0] wb_data_reg, wb_data_next;
  logic              err_reg, err_next;

  logic              accept, a_ok, b_ok, a_bad, b_bad;
  ls_entry_t         entry_a, entry_b, wr0_entry, head;
  logic              wr0_en, wr1_en, pop, empty;
  logic [CNT_W-1:0]  count;

  assign stall_o = (count > CNT_W'(DEPTH - 2));
  assign accept  = ~stall_o & ~flush_i;
  assign a_ok    = accept & loadStoreA_i &  is_ls_op(lsOpCodeA_i);
  assign b_ok    = accept & loadStoreB_i &  is_ls_op(lsOpCodeB_i);
  assign a_bad   = accept & loadStoreA_i & ~is_ls_op(lsOpCodeA_i);
  assign b_bad   = accept & loadStoreB_i & ~is_ls_op(lsOpCodeB_i);

  assign entry_a = make_entry(lsOpCodeA_i, isWbLSA_i, lsWbAddressA_i, lsPoperandA_i, lsSoperandA_i);
  assign entry_b = make_entry(lsOpCodeB_i, isWbLSB_i, lsWbAddressB_i, lsPoperandB_i, lsSoperandB_i);

  // Compact the accepted lanes so A always precedes B in the queue.
  assign wr0_en    = a_ok | b_ok;
  assign wr0_entry = a_ok ? entry_a : entry_b;
  assign wr1_en    = a_ok & b_ok;

  ls_request_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .clear     (flush_i),
    .wr0_en    (wr0_en),
    .wr0_entry (wr0_entry),
    .wr1_en    (wr1_en),
    .wr1_entry (entry_b),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  always_comb begin
    state_next   = state_reg;
    cur_next     = cur_reg;
    squash_next  = squash_reg;
    wb_en_next   = 1'b0;
    wb_addr_next = wb_addr_reg;
    wb_data_next = wb_data_reg;
    err_next     = a_bad | b_bad;
    pop          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!empty && !flush_i) begin
          pop        = 1'b1;
          cur_next   = head;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // A request in flight cannot be withdrawn; a flush only marks it squashed.
        if (flush_i) begin
          squash_next = 1'b1;
        end
        if (mem_bus.mem_ack) begin
          squash_next = 1'b0;
          if (!cur_reg.we && cur_reg.wb_en && !squash_reg && !flush_i) begin
            wb_en_next   = 1'b1;
            wb_addr_next = cur_reg.wb_addr;
            wb_data_next = mem_bus.mem_rdata;
          end
          if (!empty && !flush_i && !squash_reg) begin
            pop      = 1'b1;
            cur_next = head;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg   <= ST_IDLE;
      cur_reg     <= '0;
      squash_reg  <= 1'b0;
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_reg     <= cur_next;
      squash_reg  <= squash_next;
      wb_en_reg   <= wb_en_next;
      wb_addr_reg <= wb_addr_next;
      wb_data_reg <= wb_data_next;
      err_reg     <= err_next;
    end
  end

  assign mem_bus.mem_req   = (state_reg == ST_REQ);
  assign mem_bus.mem_we    = cur_reg.we;
  assign mem_bus.mem_addr  = cur_reg.addr;
  assign mem_bus.mem_wdata = cur_reg.data;

  assign wbEnable_o  = wb_en_reg;
  assign wbAddress_o = wb_addr_reg;
  assign wbData_o    = wb_data_reg;
  assign err_o       = err_reg;
  assign busy_o      = ~empty | (state_reg == ST_REQ);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: single load, dual issue, back-pressure,
// flush during an outstanding access, illegal opcodes and asynchronous reset.
module tb_load_store_unit;
  import ls_defs::*;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        en_a, en_b, wb_a, wb_b;
  logic [4:0]  rd_a, rd_b;
  logic [6:0]  op_a, op_b;
  logic [15:0] addr_a, addr_b, data_a, data_b;
  logic        stall, wb_en, busy, err;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data;

  logic        ack_en;
  logic [15:0] store_word;
  logic [32:0] req_log [$];
  int          wb_count;
  int          n_vec;
  int          n_miss;

  load_store_unit_if mem_bus();

  load_store_unit #(.DEPTH(4)) dut (
    .clock_i        (clock),
    .reset_i        (reset_n),
    .flush_i        (flush),
    .loadStoreA_i   (en_a),
    .loadStoreB_i   (en_b),
    .isWbLSA_i      (wb_a),
    .isWbLSB_i      (wb_b),
    .lsWbAddressA_i (rd_a),
    .lsWbAddressB_i (rd_b),
    .lsOpCodeA_i    (op_a),
    .lsOpCodeB_i    (op_b),
    .lsPoperandA_i  (addr_a),
    .lsPoperandB_i  (addr_b),
    .lsSoperandA_i  (data_a),
    .lsSoperandB_i  (data_b),
    .stall_o        (stall),
    .mem_bus        (mem_bus.master),
    .wbEnable_o     (wb_en),
    .wbAddress_o    (wb_addr),
    .wbData_o       (wb_data),
    .busy_o         (busy),
    .err_o          (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Zero-wait memory whenever ack_en is set; 0x0040 reads BEEF, elsewhere the last store.
  assign mem_bus.mem_ack   = mem_bus.mem_req & ack_en;
  assign mem_bus.mem_rdata = (mem_bus.mem_addr == 16'h0040) ? 16'hBEEF : store_word;

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_bus.mem_req && mem_bus.mem_ack) begin
        req_log.push_back({mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata});
        $display("[%0t] mem ack we=%0d addr=%h wdata=%h", $time,
                 mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata);
        if (mem_bus.mem_we) store_word <= mem_bus.mem_wdata;
      end
      if (wb_en) begin
        wb_count++;
        $display("[%0t] writeback r%0d = %h", $time, wb_addr, wb_data);
      end
    end
  end

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lane_a(input logic [6:0] op, input logic [15:0] addr, input logic [15:0] data,
                        input logic wb, input logic [4:0] rd);
    en_a = 1'b1; op_a = op; addr_a = addr; data_a = data; wb_a = wb; rd_a = rd;
  endtask

  task automatic lane_b(input logic [6:0] op, input logic [15:0] addr, input logic [15:0] data,
                        input logic wb, input logic [4:0] rd);
    en_b = 1'b1; op_b = op; addr_b = addr; data_b = data; wb_b = wb; rd_b = rd;
  endtask

  task automatic lanes_idle();
    en_a = 1'b0; en_b = 1'b0;
  endtask

  initial begin
    int wb0;
    n_vec = 0; n_miss = 0; wb_count = 0; store_word = 16'h0000;
    reset_n = 1'b0; flush = 1'b0; ack_en = 1'b0;
    en_a = 0; en_b = 0; wb_a = 0; wb_b = 0; rd_a = 0; rd_b = 0;
    op_a = 0; op_b = 0; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;

    #3;
    chk("reset_stall", stall, 0);
    chk("reset_req", mem_bus.mem_req, 0);
    chk("reset_wb", wb_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    tick();
    reset_n = 1'b1;

    // Single load, ack one cycle after the request appears
    lane_a(OP_LOAD, 16'h0040, 16'h0000, 1'b1, 5'd5);
    tick(); lanes_idle();
    chk("t1_idle_before_req", mem_bus.mem_req, 0);
    tick();
    chk("t1_req", mem_bus.mem_req, 1);
    chk("t1_we", mem_bus.mem_we, 0);
    chk("t1_addr", mem_bus.mem_addr, 16'h0040);
    tick();
    chk("t1_req_held", mem_bus.mem_req, 1);
    ack_en = 1'b1;
    tick(); ack_en = 1'b0;
    chk("t1_wb_en", wb_en, 1);
    chk("t1_wb_addr", wb_addr, 5);
    chk("t1_wb_data", wb_data, 16'hBEEF);
    chk("t1_req_drop", mem_bus.mem_req, 0);
    tick();
    chk("t1_wb_one_cycle", wb_en, 0);
    chk("t1_busy_idle", busy, 0);

    // Dual issue into a zero-wait memory: store then load of the same word
    ack_en = 1'b1;
    lane_a(OP_STORE, 16'h0010, 16'h1234, 1'b1, 5'd9);
    lane_b(OP_LOAD,  16'h0010, 16'h0000, 1'b1, 5'd3);
    tick(); lanes_idle();
    tick();
    chk("t2_first_req", mem_bus.mem_req, 1);
    chk("t2_first_we", mem_bus.mem_we, 1);
    chk("t2_first_addr", mem_bus.mem_addr, 16'h0010);
    chk("t2_first_wdata", mem_bus.mem_wdata, 16'h1234);
    tick();
    chk("t2_second_req", mem_bus.mem_req, 1);
    chk("t2_second_we", mem_bus.mem_we, 0);
    chk("t2_store_no_wb", wb_en, 0);
    tick();
    chk("t2_wb_en", wb_en, 1);
    chk("t2_wb_addr", wb_addr, 3);
    chk("t2_wb_data", wb_data, 16'h1234);
    chk("t2_req_drop", mem_bus.mem_req, 0);
    ack_en = 1'b0;
    tick();

    // Back-pressure with a memory that never acks; two store ops offered per cycle
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t3_stall_c%0d", c), stall, (c >= 2) ? 1 : 0);
      lane_a(OP_STORE, 16'h0100 + 16'(2 * c),     16'(2 * c),     1'b0, 5'd0);
      lane_b(OP_STORE, 16'h0100 + 16'(2 * c + 1), 16'(2 * c + 1), 1'b0, 5'd0);
      tick();
    end
    lanes_idle();
    chk("t3_stall_held", stall, 1);
    chk("t3_busy", busy, 1);
    req_log.delete();
    ack_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    ack_en = 1'b0;
    chk("t3_accepted_count", 33'(req_log.size()), 4);
    for (int i = 0; i < req_log.size(); i++) begin
      chk($sformatf("t3_order_%0d", i), req_log[i], {1'b1, 16'h0100 + 16'(i), 16'(i)});
    end
    chk("t3_idle_req", mem_bus.mem_req, 0);
    chk("t3_idle_busy", busy, 0);

    // Flush while a load is outstanding and two more ops are queued
    lane_a(OP_LOAD, 16'h0200, 16'h0000, 1'b1, 5'd7);
    lane_b(OP_LOAD, 16'h0201, 16'h0000, 1'b1, 5'd8);
    tick(); lanes_idle();
    lane_a(OP_LOAD, 16'h0202, 16'h0000, 1'b1, 5'd9);
    tick();
    chk("t4_req_before_flush", mem_bus.mem_req, 1);
    chk("t4_addr_before_flush", mem_bus.mem_addr, 16'h0200);
    req_log.delete();
    wb0 = wb_count;
    lane_a(OP_LOAD, 16'h02FF, 16'h0000, 1'b1, 5'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0; lanes_idle();
    chk("t4_req_held", mem_bus.mem_req, 1);
    chk("t4_addr_held", mem_bus.mem_addr, 16'h0200);
    tick();
    chk("t4_req_held2", mem_bus.mem_req, 1);
    tick();
    ack_en = 1'b1;
    tick(); ack_en = 1'b0;
    chk("t4_req_after_ack", mem_bus.mem_req, 0);
    chk("t4_busy_after_ack", busy, 0);
    tick(); tick(); tick();
    chk("t4_no_wb", 33'(wb_count), 33'(wb0));
    chk("t4_no_more_reqs", mem_bus.mem_req, 0);
    chk("t4_req_log_size", 33'(req_log.size()), 1);
    if (req_log.size() > 0) chk("t4_acked_addr", req_log[0][31:16], 16'h0200);

    // Illegal opcodes: one lane, then both lanes in one cycle
    lane_a(7'h05, 16'h0300, 16'h0000, 1'b1, 5'd1);
    tick(); lanes_idle();
    chk("t5_err_pulse", err, 1);
    chk("t5_not_queued", busy, 0);
    tick();
    chk("t5_err_clear", err, 0);
    chk("t5_no_req", mem_bus.mem_req, 0);
    lane_a(7'h05, 16'h0300, 16'h0000, 1'b1, 5'd1);
    lane_b(7'h7F, 16'h0301, 16'h0000, 1'b1, 5'd2);
    tick(); lanes_idle();
    chk("t5_dual_err", err, 1);
    tick();
    chk("t5_dual_single_pulse", err, 0);
    chk("t5_dual_no_req", mem_bus.mem_req, 0);

    // Asynchronous reset between edges with a request up and the FIFO non-empty
    lane_a(OP_LOAD, 16'h0400, 16'h0000, 1'b1, 5'd4);
    lane_b(OP_LOAD, 16'h0401, 16'h0000, 1'b1, 5'd6);
    tick(); lanes_idle();
    tick();
    chk("t6_pre_req", mem_bus.mem_req, 1);
    chk("t6_pre_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_req", mem_bus.mem_req, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_wb", wb_en, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_addr", mem_bus.mem_addr, 0);
    #2 reset_n = 1'b1;
    req_log.delete();
    ack_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_no_stale_req_%0d", i), mem_bus.mem_req, 0);
    end
    ack_en = 1'b0;
    chk("t6_no_stale_ack", 33'(req_log.size()), 0);
    chk("t6_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
